axi_req_arbiter: RTL

- Shares the single AXI-Lite master port (start_write/start_read command interface feeding the AXI-to-APB-to-UART path) between two requesters: requester 0 is the CPU LSU control-register path, requester 1 is a secondary master such as a UART RX poller or debug agent.
- Round-robin grant; one transaction in flight at a time.
- Issues one-cycle start pulses with stable address/data/strobe, waits for the B or R handshake, and routes the response back to the granted requester.
- A watchdog terminates hung transactions.

---
 rtl/axi_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 33 +++
 rtl/axi_req_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-requester AXI-Lite command arbiter.
package axi_arb_pkg;

   localparam int NUM_REQ = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT_B = 3'd2,
      ST_WAIT_R = 3'd3,
      ST_RESP   = 3'd4
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: combinational one-hot grant plus a registered
// pointer holding the index of the requester that owned the bus last.
module rr_arbiter2
   import axi_arb_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_upd,
   input  logic               i_upd_idx,
   output logic [NUM_REQ-1:0] o_gnt
);

   logic last_q;

   // A lone request wins outright; on contention the one not served last wins
   always_comb begin
      o_gnt = i_req;
      if (i_req == 2'b11) begin
         o_gnt = last_q ? 2'b01 : 2'b10;
      end
   end

   // Last-owner pointer; resetting it to 1 hands first priority to requester 0
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q <= 1'b1;
      end else if (i_upd) begin
         last_q <= i_upd_idx;
      end
   end

endmodule

// File: rtl/axi_req_arbiter.sv
// Shares one AXI-Lite command port between two requesters. One transaction is
// in flight at a time: accept, pulse start, wait for B or R, return the
// response to the owner. A watchdog turns a hung transaction into SLVERR.
module axi_req_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023   // must be >= 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [NUM_REQ-1:0]    i_req_valid,
   input  logic [NUM_REQ-1:0]    i_req_write,
   input  logic [2*ADDR_W-1:0]   i_req_addr,
   input  logic [2*DATA_W-1:0]   i_req_wdata,
   input  logic [7:0]            i_req_strb,
   output logic [NUM_REQ-1:0]    o_req_ready,
   output logic [NUM_REQ-1:0]    o_rsp_valid,
   output logic [DATA_W-1:0]     o_rsp_rdata,
   output logic [1:0]            o_rsp_resp,
   output logic                  o_rsp_timeout,
   output logic                  o_start_write,
   output logic                  o_start_read,
   output logic [ADDR_W-1:0]     o_axi_addr,
   output logic [DATA_W-1:0]     o_axi_data,
   output logic [3:0]            o_axi_strobe,
   input  logic                  i_b_valid,
   input  logic                  i_b_ready,
   input  logic [1:0]            i_b_resp,
   input  logic                  i_r_valid,
   input  logic                  i_r_ready,
   input  logic [DATA_W-1:0]     i_r_data,
   input  logic [1:0]            i_r_resp,
   output logic                  o_busy,
   output logic                  o_grant
);

   // Counter wide enough to hold TIMEOUT; it saturates instead of wrapping.
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   // The counter starts at 0 in the first wait cycle, so the watchdog fires in
   // the wait cycle where it holds TIMEOUT-1 (i.e. it would step to TIMEOUT).
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end
      return v + CNT_W'(1);
   endfunction

   arb_state_e           state_q;
   arb_state_e           state_d;
   logic [NUM_REQ-1:0]   gnt_oh;
   logic                 win_idx;
   logic                 wr_p0;
   logic [CNT_W-1:0]     cnt_p0;
   logic                 b_hs;
   logic                 r_hs;
   logic                 cnt_hit;
   logic                 rr_upd;

   assign b_hs    = i_b_valid & i_b_ready;
   assign r_hs    = i_r_valid & i_r_ready;
   assign cnt_hit = (cnt_p0 == CNT_LAST);
   assign win_idx = gnt_oh[1];
   assign o_busy  = (state_q != ST_IDLE);

   rr_arbiter2 u_rr (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_req     (i_req_valid),
      .i_upd     (rr_upd),
      .i_upd_idx (o_grant),
      .o_gnt     (gnt_oh)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and per-state strobes; a real handshake takes priority over the watchdog
   always_comb begin
      state_d       = state_q;
      o_req_ready   = '0;
      o_start_write = 1'b0;
      o_start_read  = 1'b0;
      o_rsp_valid   = '0;
      rr_upd        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|i_req_valid) begin
               // Ready is suppressed while reset is applied since nothing is accepted
               o_req_ready = i_rst ? '0 : gnt_oh;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            o_start_write = wr_p0;
            o_start_read  = !wr_p0;
            state_d       = wr_p0 ? ST_WAIT_B : ST_WAIT_R;
         end
         ST_WAIT_B: begin
            if (b_hs || cnt_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_WAIT_R: begin
            if (r_hs || cnt_hit) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            o_rsp_valid[o_grant] = 1'b1;
            rr_upd               = 1'b1;
            state_d              = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Watchdog: cleared in ISSUE, counts every wait cycle without a handshake
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_p0 <= '0;
      end else if (state_q == ST_ISSUE) begin
         cnt_p0 <= '0;
      end else if (state_q == ST_WAIT_B || state_q == ST_WAIT_R) begin
         cnt_p0 <= sat_inc(cnt_p0);
      end
   end

   // Payload latch on accept (held through IDLE afterwards) and response capture on completion
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_p0         <= 1'b0;
         o_axi_addr    <= '0;
         o_axi_data    <= '0;
         o_axi_strobe  <= '0;
         o_grant       <= 1'b0;
         o_rsp_rdata   <= '0;
         o_rsp_resp    <= RESP_OKAY;
         o_rsp_timeout <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (|i_req_valid) begin
                  wr_p0        <= i_req_write[win_idx];
                  o_axi_addr   <= win_idx ? i_req_addr[2*ADDR_W-1:ADDR_W]
                                          : i_req_addr[ADDR_W-1:0];
                  o_axi_data   <= win_idx ? i_req_wdata[2*DATA_W-1:DATA_W]
                                          : i_req_wdata[DATA_W-1:0];
                  o_axi_strobe <= win_idx ? i_req_strb[7:4] : i_req_strb[3:0];
                  o_grant      <= win_idx;
               end
            end
            ST_WAIT_B: begin
               if (b_hs) begin
                  o_rsp_rdata   <= '0;
                  o_rsp_resp    <= i_b_resp;
                  o_rsp_timeout <= 1'b0;
               end else if (cnt_hit) begin
                  o_rsp_rdata   <= '0;
                  o_rsp_resp    <= RESP_SLVERR;
                  o_rsp_timeout <= 1'b1;
               end
            end
            ST_WAIT_R: begin
               if (r_hs) begin
                  o_rsp_rdata   <= i_r_data;
                  o_rsp_resp    <= i_r_resp;
                  o_rsp_timeout <= 1'b0;
               end else if (cnt_hit) begin
                  o_rsp_rdata   <= '0;
                  o_rsp_resp    <= RESP_SLVERR;
                  o_rsp_timeout <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
